// File: rtl/lkup_ram_pkg.sv
// Shared types and helpers for the lookup-table RAM schedulers.
package lkup_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_BITS = 5;
  localparam int DEF_DATA_BITS = 38;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lkup_ram_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past each winner.
module rr_arbiter
  import lkup_ram_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_vld
);

  localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [PW-1:0] ptr_p0;
  logic [PW-1:0] gidx;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gidx    = '0;
    for (int k = 0; k < N; k++) begin
      if (en && !gnt_vld && req[PW'((int'(ptr_p0) + k) % N)]) begin
        gnt_vld = 1'b1;
        gidx    = PW'((int'(ptr_p0) + k) % N);
      end
    end
    if (gnt_vld) gnt[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= '0;
    end else if (gnt_vld) begin
      ptr_p0 <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/lkup_ram_sched.sv
// Scheduler for one dual-port lookup RAM: clears the table after reset, arbitrates
// read port B round-robin, forwards config writes to port A. Optional macro
// LKUP_RAM_SCHED_RSP_REG_EN adds an output register stage on the response.
module lkup_ram_sched
  import lkup_ram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_REQ   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic                           rsp_valid,
  output logic [NUM_REQ-1:0]             rsp_id,
  output logic [DATA_BITS-1:0]           rsp_data,
  input  logic                           cfg_wr_valid,
  input  logic [ADDR_BITS-1:0]           cfg_wr_addr,
  input  logic [DATA_BITS-1:0]           cfg_wr_data,
  output logic                           cfg_wr_ready,
  output logic                           init_done,
  output logic [ADDR_BITS-1:0]           ram_addra,
  output logic [DATA_BITS-1:0]           ram_dina,
  output logic                           ram_ena,
  output logic                           ram_wea,
  output logic [ADDR_BITS-1:0]           ram_addrb,
  output logic                           ram_enb,
  input  logic [DATA_BITS-1:0]           ram_doutb
);

  state_t               state_p0, state_nxt;
  logic [ADDR_BITS:0]   cnt_p0;
  logic [ADDR_BITS:0]   cnt_nxt;
  logic                 run;
  logic                 wr_acc;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_vld;
  logic [ADDR_BITS-1:0] gaddr;
  logic                 byp;

  // Outputs are gated by rst so the block presents its reset values while held.
  assign run     = (state_p0 == ST_RUN) && !rst;
  assign wr_acc  = run && cfg_wr_valid;
  assign cnt_nxt = cnt_p0 + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_INIT;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == ST_INIT) cnt_p0 <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_p0;
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_addra    = '0;
    ram_dina     = '0;
    init_done    = 1'b0;
    cfg_wr_ready = 1'b0;
    if (!rst) begin
      case (state_p0)
        ST_INIT: begin
          ram_ena   = 1'b1;
          ram_wea   = 1'b1;
          ram_addra = cnt_p0[ADDR_BITS-1:0];
          if (cnt_nxt[ADDR_BITS]) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          init_done    = 1'b1;
          cfg_wr_ready = 1'b1;
          ram_ena      = cfg_wr_valid;
          ram_wea      = cfg_wr_valid;
          ram_addra    = cfg_wr_addr;
          ram_dina     = cfg_wr_data;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .req     (rd_req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gaddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gaddr = rd_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  assign rd_gnt    = gnt;
  assign ram_enb   = gnt_vld;
  assign ram_addrb = gaddr;
  assign byp       = gnt_vld && wr_acc && (gaddr == cfg_wr_addr);

  // ---- p0 -> p1: grant registered, RAM read in flight
  logic                 vld_p1;
  logic [NUM_REQ-1:0]   id_p1;
  logic                 byp_p1;
  logic [DATA_BITS-1:0] wdata_p1;
  logic [DATA_BITS-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
      byp_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt_vld;
      id_p1  <= gnt;
      byp_p1 <= byp;
    end
  end

  always_ff @(posedge clk) begin
    wdata_p1 <= cfg_wr_data;
  end

  // Write-first: a same-cycle write to the read address wins over the old RAM word.
  assign data_p1 = vld_p1 ? (byp_p1 ? wdata_p1 : ram_doutb) : '0;

`ifdef LKUP_RAM_SCHED_RSP_REG_EN
  // ---- p1 -> p2: optional output register
  logic                 vld_p2;
  logic [NUM_REQ-1:0]   id_p2;
  logic [DATA_BITS-1:0] data_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  always_ff @(posedge clk) begin
    data_p2 <= data_p1;
  end

  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p2;
  assign rsp_data  = vld_p2 ? data_p2 : '0;
`else
  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_data  = data_p1;
`endif

endmodule

// File: tb/tb_lkup_ram_sched.sv
// Bench for lkup_ram_sched: RAM model, table/round-robin reference model, literal scenarios.
module tb_lkup_ram_sched;

  localparam int A = 5;
  localparam int D = 38;
  localparam int N = 4;
`ifdef LKUP_RAM_SCHED_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   rd_req;
  logic [N*A-1:0] rd_addr;
  logic [N-1:0]   rd_gnt;
  logic           rsp_valid;
  logic [N-1:0]   rsp_id;
  logic [D-1:0]   rsp_data;
  logic           cfg_wr_valid;
  logic [A-1:0]   cfg_wr_addr;
  logic [D-1:0]   cfg_wr_data;
  logic           cfg_wr_ready;
  logic           init_done;
  logic [A-1:0]   ram_addra;
  logic [D-1:0]   ram_dina;
  logic           ram_ena;
  logic           ram_wea;
  logic [A-1:0]   ram_addrb;
  logic           ram_enb;
  logic [D-1:0]   ram_doutb = '0;

  lkup_ram_sched #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ready(cfg_wr_ready), .init_done(init_done),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // Read-first RAM: a same-cycle read sees the old word.
  logic [D-1:0] mem [0:(1<<A)-1];
  initial for (int i = 0; i < (1 << A); i++) mem[i] = D'({$urandom(), $urandom()});
  always @(posedge clk) begin
    if (ram_enb) ram_doutb <= mem[ram_addrb];
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_n);
    else n_pass++;
  endfunction

  // ---------------- reference model ----------------
  logic [D-1:0] tbl [0:(1<<A)-1];
  bit           m_run = 1'b0;
  int           m_cnt = 0;
  int           m_ptr = 0;
  bit           pv   [0:1] = '{1'b0, 1'b0};
  logic [N-1:0] pid  [0:1] = '{'0, '0};
  logic [D-1:0] pdat [0:1] = '{'0, '0};
  bit           nv;
  logic [N-1:0] nid;
  logic [D-1:0] nd;
  logic [N-1:0] egnt;
  logic [A-1:0] ea;
  int           g;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("rsp_valid", rsp_valid, pv[0]);
      chk("rsp_id", rsp_id, pid[0]);
      if (pv[0]) chk("rsp_data", rsp_data, pdat[0]);
      nv = 1'b0; nid = '0; nd = '0;
      if (rst) begin
        chk("rst_gnt", rd_gnt, 0);
        chk("rst_ena", ram_ena, 0);
        chk("rst_wea", ram_wea, 0);
        chk("rst_enb", ram_enb, 0);
        chk("rst_addrb", ram_addrb, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ready", cfg_wr_ready, 0);
        m_run = 1'b0; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < 2; i++) begin pv[i] = 1'b0; pid[i] = '0; pdat[i] = '0; end
      end else begin
        if (!m_run) begin
          chk("init_done_low", init_done, 0);
          chk("init_ready_low", cfg_wr_ready, 0);
          chk("init_gnt", rd_gnt, 0);
          chk("init_enb", ram_enb, 0);
          chk("init_ena", ram_ena, 1);
          chk("init_wea", ram_wea, 1);
          chk("init_addra", ram_addra, m_cnt);
          chk("init_dina", ram_dina, 0);
          tbl[m_cnt] = '0;
          m_cnt++;
          if (m_cnt == (1 << A)) m_run = 1'b1;
        end else begin
          chk("run_init_done", init_done, 1);
          chk("run_ready", cfg_wr_ready, 1);
          chk("run_ena", ram_ena, cfg_wr_valid);
          chk("run_wea", ram_wea, cfg_wr_valid);
          if (cfg_wr_valid) begin
            chk("run_addra", ram_addra, cfg_wr_addr);
            chk("run_dina", ram_dina, cfg_wr_data);
          end
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && rd_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          egnt = '0;
          if (g >= 0) begin
            ea = rd_addr[g*A +: A];
            egnt[g] = 1'b1;
            nv = 1'b1; nid = egnt;
            nd = (cfg_wr_valid && cfg_wr_addr == ea) ? cfg_wr_data : tbl[ea];
            m_ptr = (g + 1) % N;
            chk("run_enb", ram_enb, 1);
            chk("run_addrb", ram_addrb, ea);
          end else begin
            chk("idle_enb", ram_enb, 0);
            chk("idle_addrb", ram_addrb, 0);
          end
          chk("run_gnt", rd_gnt, egnt);
          if (cfg_wr_valid) tbl[cfg_wr_addr] = cfg_wr_data;
        end
        for (int i = 0; i < LAT - 1; i++) begin
          pv[i] = pv[i+1]; pid[i] = pid[i+1]; pdat[i] = pdat[i+1];
        end
        pv[LAT-1] = nv; pid[LAT-1] = nid; pdat[LAT-1] = nd;
      end
    end
  end

  // ---------------- hand-computed literal expectations ----------------
  typedef struct {
    int           cyc;
    logic [N-1:0] id;
    logic [D-1:0] data;
  } lit_t;
  lit_t lq[$];

  initial forever begin
    @(negedge clk);
    if (lq.size() > 0 && lq[0].cyc == cyc_n) begin
      chk("lit_rsp_valid", rsp_valid, 1);
      chk("lit_rsp_id", rsp_id, lq[0].id);
      chk("lit_rsp_data", rsp_data, lq[0].data);
      void'(lq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [N-1:0] req, input logic [N*A-1:0] addrs,
                     input logic wv, input logic [A-1:0] wa, input logic [D-1:0] wd);
    rd_req = req; rd_addr = addrs;
    cfg_wr_valid = wv; cfg_wr_addr = wa; cfg_wr_data = wd;
  endtask

  function automatic logic [N*A-1:0] pk(input logic [A-1:0] a0, input logic [A-1:0] a1,
                                        input logic [A-1:0] a2, input logic [A-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic expect_rsp(input logic [N-1:0] id, input logic [D-1:0] data);
    lq.push_back('{cyc_n + LAT, id, data});
  endtask

  task automatic wait_init(output int n, output logic [A-1:0] first_addra);
    n = 0;
    first_addra = '1;
    while (n < 100) begin
      @(negedge clk);
      if (n == 0) first_addra = ram_addra;
      if (init_done) break;
      n++;
      tick();
    end
  endtask

  int           lat_n;
  logic [A-1:0] fa;

  initial begin
    rst = 1'b1;
    drv('0, '0, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    wait_init(lat_n, fa);
    chk("init_latency", lat_n, 32);
    chk("init_first_addr", fa, 0);
    tick();

    // all requesters held: 0,1,2,3,0,1,2,3
    drv(4'b1111, pk(5'd1, 5'd2, 5'd3, 5'd4), 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_seq", rd_gnt, 64'(1 << (k % N)));
      tick();
    end

    // cleared table: address 17 reads as zero
    drv(4'b0001, pk(5'd17, 5'd0, 5'd0, 5'd0), 1'b0, '0, '0);
    expect_rsp(4'b0001, '0);
    tick();
    drv('0, '0, 1'b0, '0, '0);
    repeat (3) tick();

    // write then read a cycle later by requester 2
    drv('0, '0, 1'b1, 5'd3, 38'h15_5555_5555);
    tick();
    drv(4'b0100, pk(5'd0, 5'd0, 5'd3, 5'd0), 1'b0, '0, '0);
    expect_rsp(4'b0100, 38'h15_5555_5555);
    tick();
    drv('0, '0, 1'b0, '0, '0);
    repeat (3) tick();

    // collision bypass on addr 9; addr 10 returns its stored value
    drv('0, '0, 1'b1, 5'd10, 38'h01_2345_6789);
    tick();
    drv(4'b0011, pk(5'd9, 5'd10, 5'd0, 5'd0), 1'b1, 5'd9, 38'h3F_0000_00AA);
    expect_rsp(4'b0001, 38'h3F_0000_00AA);
    tick();
    drv(4'b0010, pk(5'd9, 5'd10, 5'd0, 5'd0), 1'b0, '0, '0);
    expect_rsp(4'b0010, 38'h01_2345_6789);
    tick();
    drv('0, '0, 1'b0, '0, '0);
    repeat (3) tick();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drv(4'($urandom()), 20'($urandom()), 1'($urandom()), 5'($urandom()),
          D'({$urandom(), $urandom()}));
      tick();
    end
    drv('0, '0, 1'b0, '0, '0);
    repeat (3) tick();

    // reset with a read in flight: response dropped
    drv(4'b0001, pk(5'd5, 5'd0, 5'd0, 5'd0), 1'b0, '0, '0);
    tick();
    drv('0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;

    // reset mid-sweep at counter 12
    repeat (11) tick();
    @(negedge clk);
    chk("mid_init_addr", ram_addra, 11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(lat_n, fa);
    chk("reinit_latency", lat_n, 32);
    chk("reinit_first_addr", fa, 0);
    tick();

    // a few more random cycles after the re-sweep
    for (int i = 0; i < 100; i++) begin
      drv(4'($urandom()), 20'($urandom()), 1'($urandom()), 5'($urandom()),
          D'({$urandom(), $urandom()}));
      tick();
    end
    drv('0, '0, 1'b0, '0, '0);
    repeat (4) tick();

    chk("lit_pending", lq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
